unit_deploy_scheduler: RTL and testbench
========================================

// Module: unit_deploy_scheduler
// PURPOSE
//  Sequences the player's unit pool: sets the game tick, owns the gold balance, and arbitrates
//  purchases into free unit slots. Drives each slot's purchase/SW1-3 inputs and move/damage strobes.
//  Reports the frontmost live unit position to the enemy-side battlefront logic.
// PARAMETERS
//  NUM_SLOTS  8     number of unit slots managed (1..16)
//  TICK_DIV   1000  clk cycles per game tick (>=4)
//  GOLD_W     10    gold register width
//  GOLD_INIT  100   gold after reset
//  GOLD_MAX   1000  gold saturation ceiling (< 2**GOLD_W)
//  INCOME     5     gold added per tick
//  COST1/2/3  20/40/80  price of unit type 1/2/3
//  COOLDOWN   4     cycles after a grant before next purchase accepted (>=2)
// PORTS
//  clk            in   1            system clock
//  reset          in   1            asynchronous, active-high
//  purchase_req   in   1            one-cycle purchase request
//  purchase_type  in   2            requested unit type 1..3 (0 = invalid)
//  slot_type      in   2*NUM_SLOTS  unitType of each slot, slot i at [2i+1:2i]; 0 = free
//  slot_pos       in   9*NUM_SLOTS  position of each slot, slot i at [9i+8:9i]
//  slot_purchase  out  NUM_SLOTS    one-hot purchase pulse to the granted slot
//  slot_sel       out  3            {SW1,SW2,SW3} one-hot type select, shared by all slots
//  move_scen      out  1            move strobe to all slots, one cycle per tick
//  damage_scen    out  1            damage strobe to all slots, cycle after move_scen
//  purchase_ack   out  1            one-cycle pulse: purchase granted
//  purchase_nack  out  1            one-cycle pulse: purchase refused
//  gold           out  GOLD_W       current gold balance
//  front_pos      out  9            min position over live slots; 9'h1FF if none
//  front_valid    out  1            1 when at least one slot_type != 0
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 except gold=GOLD_INIT, front_pos=9'h1FF; tick_cnt=0, cooldown=0.
//  All outputs registered.
//  Tick: tick_cnt counts 0..TICK_DIV-1 and wraps. On the wrap edge move_scen=1 for one cycle.
//   damage_scen=1 on the following cycle. Gold += INCOME on the move_scen cycle, saturating at GOLD_MAX.
//  FSM IDLE -> CHECK -> GRANT -> COOL -> IDLE:
//   IDLE: purchase_req=1 latches purchase_type -> CHECK. Requests in any other state are dropped, no nack.
//   CHECK (1 cycle): free = lowest index i with slot_type[i]==0.
//     Refuse if type==0, no free slot, or gold < COST(type): purchase_nack pulse -> IDLE.
//     Else -> GRANT.
//   GRANT (1 cycle): slot_purchase[free]=1, slot_sel=100/010/001 for type 1/2/3.
//     purchase_ack=1, gold -= COST(type); -> COOL.
//     slot_sel returns to 000 next cycle.
//   COOL: hold COOLDOWN cycles (covers the 2-cycle slot deploy latency before slot_type goes
//     nonzero), then -> IDLE.
//  Simultaneous deduct and income in the same cycle: gold = min(gold - cost + INCOME, GOLD_MAX).
//   No underflow, since CHECK guarantees gold >= cost.
//  Free slot and cost are evaluated in CHECK. gold is re-read in GRANT, which can only have grown.
//  front_pos/front_valid: recomputed every cycle from registered slot inputs, 1-cycle latency.
//   Ties resolve to the same value.
//  The tick runs in every FSM state. The purchase path never stalls the tick.
//  Reset mid-operation: any state -> IDLE and every pulse output is deasserted asynchronously.
// TESTING
//  1 Reset, wait 2*TICK_DIV: move_scen pulses at cycles TICK_DIV and 2*TICK_DIV.
//    damage_scen follows each by 1 cycle; gold 100->105->110.
//  2 All slots free, req type 2 -> ack, slot_purchase=8'h01, slot_sel=010 same cycle, gold 100->60.
//  3 slot_type=16'h0005 (slots 0,1 used), req type 1 -> slot_purchase=8'h04, gold -20.
//  4 gold=30, req type 3 -> nack, gold unchanged, no slot_purchase. Type 0 -> nack. All slots used -> nack.
//  5 Grant lands on tick cycle: gold = old - cost + 5. gold=998 and tick, no purchase -> gold=1000.
//  6 Live slots with pos {200,150,300} -> front_pos=150, valid=1. All free -> 1FF, valid=0.
//    Assert reset during GRANT -> all pulse outputs 0 immediately.

Source files
------------

// File: rtl/unit_deploy_scheduler.sv
// -----------------------------------------------------------------------------
// unit_deploy_scheduler
//
// Sequences the player's unit pool. It generates the game tick, owns the gold
// balance, and arbitrates purchase requests into the lowest-numbered free unit
// slot. It also reports the frontmost live unit position to the battlefront.
//
// Ports
//   clk            system clock
//   reset          asynchronous, active-high
//   purchase_req   one-cycle purchase request (accepted only when idle)
//   purchase_type  requested unit type 1..3 (0 = invalid)
//   slot_type      per-slot unit type, slot i at [2i+1:2i], 0 = free
//   slot_pos       per-slot position, slot i at [9i+8:9i]
//   slot_purchase  one-hot purchase pulse to the granted slot
//   slot_sel       {SW1,SW2,SW3} one-hot type select shared by all slots
//   move_scen      move strobe, one cycle per game tick
//   damage_scen    damage strobe, the cycle after move_scen
//   purchase_ack   one-cycle pulse: purchase granted
//   purchase_nack  one-cycle pulse: purchase refused
//   gold           current gold balance
//   front_pos      minimum position over live slots, 9'h1FF when none
//   front_valid    at least one slot is live
// -----------------------------------------------------------------------------
module unit_deploy_scheduler #(
    parameter int NUM_SLOTS = 8,
    parameter int TICK_DIV  = 1000,
    parameter int GOLD_W    = 10,
    parameter int GOLD_INIT = 100,
    parameter int GOLD_MAX  = 1000,
    parameter int INCOME    = 5,
    parameter int COST1     = 20,
    parameter int COST2     = 40,
    parameter int COST3     = 80,
    parameter int COOLDOWN  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     purchase_req,
    input  logic [1:0]               purchase_type,
    input  logic [2*NUM_SLOTS-1:0]   slot_type,
    input  logic [9*NUM_SLOTS-1:0]   slot_pos,
    output logic [NUM_SLOTS-1:0]     slot_purchase,
    output logic [2:0]               slot_sel,
    output logic                     move_scen,
    output logic                     damage_scen,
    output logic                     purchase_ack,
    output logic                     purchase_nack,
    output logic [GOLD_W-1:0]        gold,
    output logic [8:0]               front_pos,
    output logic                     front_valid
);

    localparam int TICK_W = $clog2(TICK_DIV);
    localparam int CD_W   = $clog2(COOLDOWN);
    // Two spare bits so income can be added before saturation is applied.
    localparam int SUM_W  = GOLD_W + 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        GRANT = 2'd2,
        COOL  = 2'd3
    } state_t;

    state_t                 state_reg, state_next;
    logic [1:0]             type_reg, type_next;
    logic [CD_W-1:0]        cd_reg, cd_next;
    logic [TICK_W-1:0]      tick_cnt_reg;
    logic                   move_scen_reg, damage_scen_reg;
    logic [GOLD_W-1:0]      gold_reg, gold_next;
    logic                   ack_reg, ack_next;
    logic                   nack_reg, nack_next;
    logic [NUM_SLOTS-1:0]   slot_purchase_reg, slot_purchase_next;
    logic [2:0]             slot_sel_reg, slot_sel_next;
    logic [8:0]             front_pos_reg, front_pos_next;
    logic                   front_valid_reg, front_valid_next;

    logic                   tick_wrap;
    logic                   deduct;
    logic [GOLD_W-1:0]      cost;
    logic [SUM_W-1:0]       gold_sum;

    // ------------------------------------------------------------------
    // Per-slot decode
    // ------------------------------------------------------------------
    logic [NUM_SLOTS-1:0]   slot_free;
    logic [8:0]             pos_a [NUM_SLOTS];

    generate
        for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
            assign slot_free[gi] = (slot_type[2*gi +: 2] == 2'b00);
            assign pos_a[gi]     = slot_pos[9*gi +: 9];
        end
    endgenerate

    // Lowest-index free slot as a one-hot vector.
    logic [NUM_SLOTS-1:0]   free_onehot;
    logic                   free_found;

    always_comb begin
        free_onehot = '0;
        free_found  = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (slot_free[i] && !free_found) begin
                free_onehot[i] = 1'b1;
            end
            free_found = free_found | slot_free[i];
        end
    end

    // Frontmost (minimum) position over live slots; ties give the same value.
    always_comb begin
        front_pos_next   = 9'h1FF;
        front_valid_next = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!slot_free[i]) begin
                front_valid_next = 1'b1;
                if (pos_a[i] < front_pos_next) begin
                    front_pos_next = pos_a[i];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Tick and gold
    // ------------------------------------------------------------------
    assign tick_wrap = (tick_cnt_reg == TICK_W'(TICK_DIV - 1));

    always_comb begin
        case (type_reg)
            2'd1:    cost = GOLD_W'(COST1);
            2'd2:    cost = GOLD_W'(COST2);
            2'd3:    cost = GOLD_W'(COST3);
            default: cost = '0;
        endcase
    end

    // Deduction happens on leaving GRANT using the gold held in GRANT; CHECK
    // already proved gold >= cost and gold can only have grown since, so the
    // difference never goes negative. Income on the same edge is folded in
    // before saturating.
    always_comb begin
        gold_sum = {2'b00, gold_reg}
                 + (tick_wrap ? SUM_W'(INCOME) : '0)
                 - (deduct ? {2'b00, cost} : '0);
        if (gold_sum > SUM_W'(GOLD_MAX)) begin
            gold_next = GOLD_W'(GOLD_MAX);
        end else begin
            gold_next = gold_sum[GOLD_W-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Purchase FSM (next state and registered-output next values)
    // ------------------------------------------------------------------
    always_comb begin
        state_next         = state_reg;
        type_next          = type_reg;
        cd_next            = cd_reg;
        ack_next           = 1'b0;
        nack_next          = 1'b0;
        slot_purchase_next = '0;
        slot_sel_next      = 3'b000;
        deduct             = 1'b0;

        case (state_reg)
            IDLE: begin
                if (purchase_req) begin
                    type_next  = purchase_type;
                    state_next = CHECK;
                end
            end
            CHECK: begin
                if ((type_reg == 2'd0) || !free_found || (gold_reg < cost)) begin
                    nack_next  = 1'b1;
                    state_next = IDLE;
                end else begin
                    // Grant pulses are registered here so they are visible
                    // for exactly the cycle spent in GRANT.
                    ack_next           = 1'b1;
                    slot_purchase_next = free_onehot;
                    case (type_reg)
                        2'd1:    slot_sel_next = 3'b100;
                        2'd2:    slot_sel_next = 3'b010;
                        default: slot_sel_next = 3'b001;
                    endcase
                    state_next = GRANT;
                end
            end
            GRANT: begin
                deduct     = 1'b1;
                cd_next    = CD_W'(COOLDOWN - 1);
                state_next = COOL;
            end
            COOL: begin
                // Holds long enough for the granted slot to report a nonzero
                // type before another free-slot search can run.
                if (cd_reg == '0) begin
                    state_next = IDLE;
                end else begin
                    cd_next = cd_reg - 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg         <= IDLE;
            type_reg          <= 2'd0;
            cd_reg            <= '0;
            tick_cnt_reg      <= '0;
            move_scen_reg     <= 1'b0;
            damage_scen_reg   <= 1'b0;
            gold_reg          <= GOLD_W'(GOLD_INIT);
            ack_reg           <= 1'b0;
            nack_reg          <= 1'b0;
            slot_purchase_reg <= '0;
            slot_sel_reg      <= 3'b000;
            front_pos_reg     <= 9'h1FF;
            front_valid_reg   <= 1'b0;
        end else begin
            state_reg         <= state_next;
            type_reg          <= type_next;
            cd_reg            <= cd_next;
            tick_cnt_reg      <= tick_wrap ? '0 : tick_cnt_reg + 1'b1;
            move_scen_reg     <= tick_wrap;
            damage_scen_reg   <= move_scen_reg;
            gold_reg          <= gold_next;
            ack_reg           <= ack_next;
            nack_reg          <= nack_next;
            slot_purchase_reg <= slot_purchase_next;
            slot_sel_reg      <= slot_sel_next;
            front_pos_reg     <= front_pos_next;
            front_valid_reg   <= front_valid_next;
        end
    end

    assign slot_purchase = slot_purchase_reg;
    assign slot_sel      = slot_sel_reg;
    assign move_scen     = move_scen_reg;
    assign damage_scen   = damage_scen_reg;
    assign purchase_ack  = ack_reg;
    assign purchase_nack = nack_reg;
    assign gold          = gold_reg;
    assign front_pos     = front_pos_reg;
    assign front_valid   = front_valid_reg;

endmodule

// File: tb/tb_unit_deploy_scheduler.sv
// -----------------------------------------------------------------------------
// tb_unit_deploy_scheduler
//
// Directed bench for unit_deploy_scheduler with a short game tick. Inputs are
// driven and outputs sampled on the falling edge. A small gold model tracks
// income on every tick edge and the deduction on the edge leaving GRANT.
// -----------------------------------------------------------------------------
module tb_unit_deploy_scheduler;

    localparam int TD = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         purchase_req = 1'b0;
    logic [1:0]   purchase_type = 2'd0;
    logic [15:0]  slot_type = 16'h0000;
    logic [71:0]  slot_pos = '0;
    logic [7:0]   slot_purchase;
    logic [2:0]   slot_sel;
    logic         move_scen;
    logic         damage_scen;
    logic         purchase_ack;
    logic         purchase_nack;
    logic [9:0]   gold;
    logic [8:0]   front_pos;
    logic         front_valid;

    unit_deploy_scheduler #(
        .NUM_SLOTS (8),
        .TICK_DIV  (TD),
        .GOLD_W    (10),
        .GOLD_INIT (100),
        .GOLD_MAX  (1000),
        .INCOME    (5),
        .COST1     (20),
        .COST2     (40),
        .COST3     (80),
        .COOLDOWN  (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .purchase_req  (purchase_req),
        .purchase_type (purchase_type),
        .slot_type     (slot_type),
        .slot_pos      (slot_pos),
        .slot_purchase (slot_purchase),
        .slot_sel      (slot_sel),
        .move_scen     (move_scen),
        .damage_scen   (damage_scen),
        .purchase_ack  (purchase_ack),
        .purchase_nack (purchase_nack),
        .gold          (gold),
        .front_pos     (front_pos),
        .front_valid   (front_valid)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int gold_exp = 100;
    int pend = 0;

    typedef struct packed {
        logic [15:0] stype;
        logic [71:0] pos;
        logic [8:0]  fpos;
        logic        fvalid;
    } fvec_t;

    typedef struct packed {
        logic [15:0] stype;
        logic [1:0]  ptype;
        logic        ack;
        logic [7:0]  sp;
        logic [2:0]  sel;
        logic        poke;
    } pvec_t;

    fvec_t fv [5];
    pvec_t pv [7];

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     nm, act, act, exp, exp, cyc);
        end
    endtask

    // One clock: model income on tick edges and any pending deduction.
    task automatic step();
        @(posedge clk);
        cyc++;
        gold_exp = gold_exp - pend + (((cyc % TD) == 0) ? 5 : 0);
        if (gold_exp > 1000) gold_exp = 1000;
        pend = 0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        purchase_req = 1'b0;
        purchase_type = 2'd0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        cyc = 0;
        gold_exp = 100;
        pend = 0;
    endtask

    // Step until the grant deduction edge of a purchase issued now would land
    // on a tick edge.
    task automatic align_grant_to_tick();
        for (int n = 0; n < TD && ((cyc + 3) % TD) != 0; n++) step();
    endtask

    task automatic purchase(input string nm, input logic [1:0] t, input logic exp_ack,
                            input logic [7:0] exp_sp, input logic [2:0] exp_sel,
                            input logic poke);
        int cost;
        cost = (t == 2'd1) ? 20 : (t == 2'd2) ? 40 : (t == 2'd3) ? 80 : 0;
        purchase_req = 1'b1;
        purchase_type = t;
        step();                      // request latched, now in CHECK
        purchase_req = 1'b0;
        purchase_type = 2'd0;
        step();                      // decision registered
        $display("purchase %s type=%0d ack=%0d nack=%0d slot_purchase=%02h sel=%03b gold=%0d",
                 nm, t, purchase_ack, purchase_nack, slot_purchase, slot_sel, gold);
        check({nm, ".ack"}, int'(purchase_ack), int'(exp_ack));
        check({nm, ".nack"}, int'(purchase_nack), int'(!exp_ack));
        check({nm, ".slot_purchase"}, int'(slot_purchase), int'(exp_sp));
        check({nm, ".slot_sel"}, int'(slot_sel), int'(exp_sel));
        check({nm, ".gold_pre"}, int'(gold), gold_exp);
        if (exp_ack) begin
            pend = cost;
            step();                  // leaving GRANT: deduction applied
            check({nm, ".gold_post"}, int'(gold), gold_exp);
            check({nm, ".sel_clear"}, int'(slot_sel), 0);
            check({nm, ".pulse_clear"}, int'({purchase_ack, slot_purchase}), 0);
            for (int c = 0; c < 4; c++) begin
                if (poke && c == 0) begin
                    purchase_req = 1'b1;
                    purchase_type = 2'd1;
                end
                step();
                purchase_req = 1'b0;
                purchase_type = 2'd0;
                check({nm, ".cool_quiet"}, int'({purchase_ack, purchase_nack}), 0);
            end
        end
    endtask

    initial begin
        int old;

        // front_pos vectors: {slot_type, slot_pos, front_pos, front_valid}
        fv[0] = '{16'h0000, {8{9'd7}}, 9'h1FF, 1'b0};
        fv[1] = '{16'h0039, {45'd0, 9'd300, 9'd150, 9'd200}, 9'd150, 1'b1};
        fv[2] = '{16'h4000, {9'h1FE, 63'd0}, 9'h1FE, 1'b1};
        fv[3] = '{16'h3840, {9'd0, 9'd9, 9'd5, 9'd0, 9'd5, 9'd0, 9'd0, 9'd1}, 9'd5, 1'b1};
        fv[4] = '{16'h0200, {27'd0, 9'h1FF, 36'd0}, 9'h1FF, 1'b1};

        // purchase vectors: {slot_type, type, ack, slot_purchase, slot_sel, poke}
        pv[0] = '{16'h0000, 2'd2, 1'b1, 8'h01, 3'b010, 1'b1};
        pv[1] = '{16'h0005, 2'd1, 1'b1, 8'h04, 3'b100, 1'b0};
        pv[2] = '{16'h0000, 2'd0, 1'b0, 8'h00, 3'b000, 1'b0};
        pv[3] = '{16'hFFFF, 2'd1, 1'b0, 8'h00, 3'b000, 1'b0};
        pv[4] = '{16'h1555, 2'd1, 1'b1, 8'h80, 3'b100, 1'b0};
        pv[5] = '{16'h0000, 2'd3, 1'b0, 8'h00, 3'b000, 1'b0};
        pv[6] = '{16'hFFF3, 2'd1, 1'b1, 8'h02, 3'b100, 1'b0};

        do_reset();

        // Reset state
        check("rst.gold", int'(gold), 100);
        check("rst.front_pos", int'(front_pos), 9'h1FF);
        check("rst.front_valid", int'(front_valid), 0);
        check("rst.strobes", int'({move_scen, damage_scen}), 0);
        check("rst.ack_nack", int'({purchase_ack, purchase_nack}), 0);
        check("rst.slot_purchase", int'(slot_purchase), 0);
        check("rst.slot_sel", int'(slot_sel), 0);
        $display("reset gold=%0d front_pos=%03h", gold, front_pos);

        // Tick strobes and income over two ticks
        for (int k = 0; k < 2*TD + 1; k++) begin
            step();
            check("tick.move_scen", int'(move_scen), ((cyc % TD) == 0) ? 1 : 0);
            check("tick.damage_scen", int'(damage_scen),
                  (((cyc % TD) == 1) && (cyc > 1)) ? 1 : 0);
            if (cyc == TD)   check("tick.gold1", int'(gold), 105);
            if (cyc == 2*TD) check("tick.gold2", int'(gold), 110);
        end
        $display("tick two periods done gold=%0d", gold);

        // Frontmost live position
        for (int i = 0; i < 5; i++) begin
            slot_type = fv[i].stype;
            slot_pos = fv[i].pos;
            step();
            $display("front vec %0d front_pos=%03h valid=%0d", i, front_pos, front_valid);
            check("front.pos", int'(front_pos), int'(fv[i].fpos));
            check("front.valid", int'(front_valid), int'(fv[i].fvalid));
        end

        // Purchase arbitration
        for (int i = 0; i < 7; i++) begin
            slot_type = pv[i].stype;
            purchase($sformatf("vec%0d", i), pv[i].ptype, pv[i].ack, pv[i].sp,
                     pv[i].sel, pv[i].poke);
        end

        // Grant deduction coinciding with income
        slot_type = 16'h0000;
        align_grant_to_tick();
        old = gold_exp;
        purchase("tick_grant", 2'd1, 1'b1, 8'h01, 3'b100, 1'b0);
        check("tick_grant.gold", int'(gold), old - 20 + 5);

        // Exact-balance grant, dropped request in cooldown, empty-purse refusal
        do_reset();
        purchase("seqA_t1", 2'd1, 1'b1, 8'h01, 3'b100, 1'b1);
        check("seqA.gold80", int'(gold), 80);
        purchase("seqA_t3_exact", 2'd3, 1'b1, 8'h01, 3'b001, 1'b0);
        check("seqA.gold0", int'(gold), 0);
        purchase("seqA_broke", 2'd1, 1'b0, 8'h00, 3'b000, 1'b0);
        check("seqA.gold5", int'(gold), 5);

        // Saturation at the ceiling
        for (int n = 0; n < 6000 && gold_exp < 1000; n++) step();
        check("sat.reach", int'(gold), 1000);
        for (int n = 0; n < TD; n++) step();
        check("sat.hold", int'(gold), 1000);
        $display("saturation gold=%0d", gold);
        align_grant_to_tick();
        purchase("sat_grant", 2'd1, 1'b1, 8'h01, 3'b100, 1'b0);
        check("sat_grant.gold", int'(gold), 985);

        // Asynchronous reset while in GRANT
        slot_type = 16'h0001;
        slot_pos = {63'd0, 9'd42};
        step();
        check("pre_rst.front_pos", int'(front_pos), 42);
        purchase_req = 1'b1;
        purchase_type = 2'd2;
        step();
        purchase_req = 1'b0;
        purchase_type = 2'd0;
        step();
        check("grant_rst.ack_before", int'(purchase_ack), 1);
        #2 reset = 1'b1;
        #1;
        $display("reset in grant ack=%0d slot_purchase=%02h sel=%03b gold=%0d",
                 purchase_ack, slot_purchase, slot_sel, gold);
        check("grant_rst.ack", int'(purchase_ack), 0);
        check("grant_rst.slot_purchase", int'(slot_purchase), 0);
        check("grant_rst.slot_sel", int'(slot_sel), 0);
        check("grant_rst.gold", int'(gold), 100);
        check("grant_rst.front_pos", int'(front_pos), 9'h1FF);
        @(negedge clk);
        reset = 1'b0;
        cyc = 0;
        gold_exp = 100;
        pend = 0;
        slot_type = 16'h0000;
        purchase("post_rst", 2'd3, 1'b1, 8'h01, 3'b001, 1'b0);
        check("post_rst.gold", int'(gold), 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
